// File: rtl/serial_src_pkg.sv
// Shared types and width constants for the serial bit source and its word FIFO.
package serial_src_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int LEN_W      = $clog2(DATA_W_DEF) + 1;
  localparam int LVL_W      = $clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/word_fifo.sv
// Circular word FIFO holding {len, data} pairs; a pop never frees a slot for a push in the same cycle.
module word_fifo
  import serial_src_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LEN_BITS = LEN_W,
  parameter int LVL_BITS = LVL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [LEN_BITS-1:0] pushLen_i,
  input  logic [DATA_W-1:0]   pushData_i,
  input  logic                pop_i,
  output logic [LEN_BITS-1:0] headLen_o,
  output logic [DATA_W-1:0]   headData_o,
  output logic [LVL_BITS-1:0] level_o
);

  localparam int PtrW = $clog2(DEPTH);

  logic [LEN_BITS+DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]            wrPtr_q;
  logic [PtrW-1:0]            rdPtr_q;
  logic [LVL_BITS-1:0]        count_q;
  logic                       doPush;
  logic                       doPop;

  // Fullness is judged on the current count, so a same-cycle pop cannot admit a push.
  assign doPush = push_i && (count_q != LVL_BITS'(DEPTH));
  assign doPop  = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PtrW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + LVL_BITS'(1);
        2'b01:   count_q <= count_q - LVL_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= {pushLen_i, pushData_i};
  end

  assign {headLen_o, headData_o} = mem_q[rdPtr_q];
  assign level_o = count_q;

endmodule

// File: rtl/serial_bit_source.sv
// Serializes queued words MSB-first onto x, one bit per enabled cycle, chaining words without gaps.
module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        load_data,
  input  logic [$clog2(DATA_W):0]  load_len,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     enable,
  output logic                     x,
  output logic                     x_valid,
  output logic                     word_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LenW = $clog2(DATA_W) + 1;
  localparam int LvlW = $clog2(DEPTH) + 1;

  state_t            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [LenW-1:0]   cnt_q;
  logic              lastX_q;

  logic [LenW-1:0]   clampedLen;
  logic              pushFire;
  logic              popFire;
  logic              lastBit;
  logic [LenW-1:0]   headLen;
  logic [DATA_W-1:0] headData;
  logic [DATA_W-1:0] headAligned_d;

  assign load_ready = level < LvlW'(DEPTH);
  assign clampedLen = (load_len > LenW'(DATA_W)) ? LenW'(DATA_W) : load_len;
  // Zero-length words complete the handshake but never reach the FIFO.
  assign pushFire   = load_valid && load_ready && (load_len != '0);

  assign lastBit       = (cnt_q == LenW'(1));
  assign popFire       = enable && (level != '0) &&
                         ((state_q == IDLE) || ((state_q == SHIFT) && lastBit));
  assign headAligned_d = headData << (DATA_W - int'(headLen));

  word_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LEN_BITS(LenW),
    .LVL_BITS(LvlW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (pushFire),
    .pushLen_i (clampedLen),
    .pushData_i(load_data),
    .pop_i     (popFire),
    .headLen_o (headLen),
    .headData_o(headData),
    .level_o   (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      lastX_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (popFire) begin
            sr_q    <= headAligned_d;
            cnt_q   <= headLen;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            lastX_q <= sr_q[DATA_W-1];
            if (lastBit) begin
              // Reload on the final bit's edge so back-to-back words have no bubble.
              if (popFire) begin
                sr_q  <= headAligned_d;
                cnt_q <= headLen;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              sr_q  <= sr_q << 1;
              cnt_q <= cnt_q - LenW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_valid   = (state_q == SHIFT) && enable;
  assign x         = (state_q == SHIFT) ? (enable ? sr_q[DATA_W-1] : lastX_q) : 1'b0;
  assign word_done = x_valid && lastBit;

endmodule

// File: tb/tb_serial_bit_source.sv
// Scoreboard bench for serial_bit_source: table-driven words plus hand-built timing and reset sequences.
module tb_serial_bit_source;

  logic        clk;
  logic        reset;
  logic [15:0] load_data;
  logic [4:0]  load_len;
  logic        load_valid;
  logic        load_ready;
  logic        enable;
  logic        x;
  logic        x_valid;
  logic        word_done;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;
  int validCount = 0;

  typedef struct packed {
    logic bitVal;
    logic done;
  } sbEntry_t;

  sbEntry_t sb[$];

  typedef struct {
    logic [4:0]  len;
    logic [15:0] data;
    int          expCnt;
    logic [15:0] expStream;
  } vec_t;

  vec_t vecs[8];

  serial_bit_source #(.DATA_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_data (load_data),
    .load_len  (load_len),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .enable    (enable),
    .x         (x),
    .x_valid   (x_valid),
    .word_done (word_done),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input int cnt, input logic [15:0] stream);
    for (int i = cnt - 1; i >= 0; i--) begin
      sb.push_back('{bitVal: stream[i], done: (i == 0)});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [4:0] len, input logic [15:0] data,
                               input int expCnt, input logic [15:0] expStream);
    int guard = 0;
    load_len   = len;
    load_data  = data;
    load_valid = 1'b1;
    while (!load_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("loadReadyTimeout", 32'(load_ready), 32'd1);
    end else begin
      @(posedge clk);
      pushExpected(expCnt, expStream);
      #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checkOutput(name, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    sbEntry_t e;
    if (reset && x_valid) begin
      validCount++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpectedBit: got x=%0b word_done=%0b, expected no output", x, word_done);
      end else begin
        e = sb.pop_front();
        if (x !== e.bitVal || word_done !== e.done) begin
          fails++;
          $display("[TB] FAIL bitStream: got x=%0b word_done=%0b, expected x=%0b word_done=%0b",
                   x, word_done, e.bitVal, e.done);
        end
      end
    end
    if (reset && word_done && !x_valid) begin
      tests++;
      fails++;
      $display("[TB] FAIL doneWithoutValid: got word_done=1, expected 0");
    end
  end

  initial begin
    logic prevX;
    int   startCount;
    int   guard;

    vecs[0] = '{5'd11, 16'h0366, 11, 16'h0366};
    vecs[1] = '{5'd4,  16'h0006, 4,  16'h0006};
    vecs[2] = '{5'd3,  16'h0006, 3,  16'h0006};
    vecs[3] = '{5'd0,  16'hFFFF, 0,  16'h0000};
    vecs[4] = '{5'd20, 16'hFFFF, 16, 16'hFFFF};
    vecs[5] = '{5'd16, 16'hA5C3, 16, 16'hA5C3};
    vecs[6] = '{5'd1,  16'hFFF1, 1,  16'h0001};
    vecs[7] = '{5'd8,  16'hAB5A, 8,  16'h005A};

    reset      = 1'b0;
    load_data  = '0;
    load_len   = '0;
    load_valid = 1'b0;
    enable     = 1'b0;
    prevX      = 1'b0;

    #1;
    checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstReady", 32'(load_ready), 32'd1);
    checkOutput("rstXValid", 32'(x_valid), 32'd0);
    checkOutput("rstX", 32'(x), 32'd0);
    checkOutput("rstDone", 32'(word_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    enable = 1'b1;
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].len, vecs[v].data, vecs[v].expCnt, vecs[v].expStream);
    end
    waitDrain("tableDrain");

    applyStimulus(5'd11, 16'h0366, 11, 16'h0366);
    @(negedge clk);
    checkOutput("latencyCycle1", 32'(x_valid), 32'd0);
    @(negedge clk);
    checkOutput("latencyCycle2", 32'(x_valid), 32'd1);
    waitDrain("latencyDrain");

    applyStimulus(5'd4, 16'h0006, 4, 16'h0006);
    applyStimulus(5'd3, 16'h0006, 3, 16'h0006);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput($sformatf("contig%0d", i), 32'(x_valid), 32'd1);
    end
    @(negedge clk);
    checkOutput("contigEnd", 32'(x_valid), 32'd0);
    waitDrain("contigDrain");

    enable = 1'b0;
    applyStimulus(5'd8, 16'h0081, 8, 16'h0081);
    applyStimulus(5'd8, 16'h0042, 8, 16'h0042);
    applyStimulus(5'd8, 16'h0024, 8, 16'h0024);
    checkOutput("level3", 32'(level), 32'd3);
    applyStimulus(5'd8, 16'h0018, 8, 16'h0018);
    checkOutput("fullLevel", 32'(level), 32'd4);
    checkOutput("fullReady", 32'(load_ready), 32'd0);
    load_len   = 5'd8;
    load_data  = 16'h00F0;
    load_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("heldReady", 32'(load_ready), 32'd0);
      checkOutput("heldLevel", 32'(level), 32'd4);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    applyStimulus(5'd8, 16'h00F0, 8, 16'h00F0);
    waitDrain("fullDrain");

    applyStimulus(5'd8, 16'h00A5, 8, 16'h00A5);
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      enable = (i % 2 == 0);
      @(negedge clk);
      if (enable) begin
        prevX = x;
      end else begin
        checkOutput($sformatf("gapValid%0d", i), 32'(x_valid), 32'd0);
        checkOutput($sformatf("gapHoldX%0d", i), 32'(x), 32'(prevX));
      end
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    waitDrain("toggleDrain");

    applyStimulus(5'd11, 16'h0366, 11, 16'h0366);
    applyStimulus(5'd11, 16'h07FF, 11, 16'h07FF);
    applyStimulus(5'd11, 16'h0555, 11, 16'h0555);
    startCount = validCount - 1;
    guard = 0;
    while (validCount < startCount + 4 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("midWordTimeout", 32'(validCount - startCount), 32'd4);
    #1;
    checkOutput("preResetLevel", 32'(level), 32'd2);
    reset = 1'b0;
    #1;
    checkOutput("midRstX", 32'(x), 32'd0);
    checkOutput("midRstXValid", 32'(x_valid), 32'd0);
    checkOutput("midRstLevel", 32'(level), 32'd0);
    checkOutput("midRstDone", 32'(word_done), 32'd0);
    checkOutput("midRstReady", 32'(load_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("postRstIdle%0d", i), 32'(x_valid), 32'd0);
    end
    checkOutput("postRstLevel", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
